axi4l_wb_bridge: RTL and testbench
==================================

AXI4L_WB_BRIDGE -- requirements
Module: axi4l_wb_bridge

Interface
REQ-001 Parameter ADDR_SHIFT, default 2: AXI byte-address right shift applied to form wb_adr_o.
REQ-002 Parameter WB_DW, default 8: Wishbone data width; legal values 8, 16, 32.
REQ-003 Parameter LANE, default 2: index of the WB_DW-wide lane of the 32-bit AXI data bus that carries Wishbone data; LANE < 32/WB_DW.
REQ-004 Parameter WB_AW, default 3: Wishbone address width.
REQ-005 Parameter TIMEOUT_CYCLES, default 255: Wishbone wait limit in cycles, 1..65535.
REQ-006 clk_i  in  1  single clock.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 slave  AXI_LITE.in  32-bit address and data  AXI4-Lite slave port.
REQ-009 wb_adr_o  out  WB_AW  Wishbone address.
REQ-010 wb_dat_o  out  WB_DW  Wishbone write data.
REQ-011 wb_sel_o  out  WB_DW/8  Wishbone byte selects.
REQ-012 wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  Wishbone classic master controls.
REQ-013 wb_dat_i  in  WB_DW  Wishbone read data.
REQ-014 wb_ack_i, wb_err_i  in  1 each  Wishbone cycle termination.

Function
REQ-015 FSM states: IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
REQ-016 IDLE: a write is eligible when aw_valid and w_valid are both high; a read is eligible when ar_valid is high.
REQ-017 When both are eligible in the same cycle, the type not served last wins; after reset, read wins first.
REQ-018 Acceptance: the accepted channel's ready signals (aw_ready and w_ready together, or ar_ready) are high for exactly that one IDLE cycle; all ready signals are low in every other state.
REQ-019 On acceptance, the bridge latches wb_adr_o = addr[ADDR_SHIFT+WB_AW-1:ADDR_SHIFT], wb_dat_o = w_data lane LANE, and wb_sel_o = w_strb lane LANE (all ones for reads).
REQ-020 Write with an all-zero strobe lane: no Wishbone cycle is issued; the FSM goes directly to B_RESP with OKAY.
REQ-021 wb_cyc_o and wb_stb_o assert on the cycle after acceptance; they hold, with wb_we_o and address/data stable, until a cycle with wb_ack_i or wb_err_i, then deassert on the next cycle.
REQ-022 wb_ack_i together with wb_err_i in the same cycle is treated as an error.
REQ-023 Read termination: r_data = wb_dat_i, captured on the ack cycle, placed in lane LANE; all other bits are 0.
REQ-024 b_valid / r_valid assert on the cycle after termination and hold with stable resp/data until the ready handshake, then return to IDLE.
REQ-025 Response encoding: ack gives OKAY (2'b00); err gives SLVERR (2'b10) with r_data = 0.
REQ-026 Throughput: one outstanding transaction; minimum write latency, AW/W acceptance to b_valid, is 2 cycles with zero-wait ack.
REQ-027 wb_ack_i or wb_err_i arriving while wb_cyc_o is low is ignored.

Reset
REQ-028 rst_i, sampled on a clk_i edge, returns the FSM to IDLE regardless of state and aborts any Wishbone cycle in flight without generating a response.
REQ-029 Reset values: all ready and valid outputs 0, wb_cyc_o/wb_stb_o/wb_we_o 0, wb_adr_o/wb_dat_o/wb_sel_o 0, b_resp/r_resp 0, r_data 0, priority set to read, timeout counter 0.

Configuration
REQ-030 Macro WB_TIMEOUT_EN defined: a counter clears on entry to WB_WR/WB_RD and increments each cycle without termination; at count TIMEOUT_CYCLES the bridge drops cyc/stb and responds SLVERR (r_data 0).
REQ-031 Macro WB_TIMEOUT_EN undefined: no counter is built; the bridge waits indefinitely for ack/err.

Verification
REQ-032 Write addr 0x0C, data 0x00AB0000, strb 0x4, ack after 1 wait -> wb_adr_o=3, wb_dat_o=0xAB, wb_sel_o=1, one stb pulse window, b_resp=OKAY.
REQ-033 Read addr 0x14, wb_dat_i=0x5A on ack -> r_data=0x005A0000, r_resp=OKAY; r_valid held through 3 cycles of r_ready low.
REQ-034 AR and AW+W valid in the same cycle twice in succession -> read served first, then write; third collision -> read served again.
REQ-035 Write with strb 0xB (lane 2 clear) -> no wb_cyc_o assertion, b_resp=OKAY 1 cycle after acceptance.
REQ-036 Read terminated by wb_err_i -> r_resp=SLVERR, r_data=0; with WB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> cyc drops after 4 cycles, SLVERR.
REQ-037 rst_i asserted mid WB_RD -> next cycle wb_cyc_o=0, r_valid=0, FSM in IDLE, and a following read completes normally.

Source files
------------

// File: rtl/axi4l_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge, one transaction in flight.
// Optional Wishbone wait timeout is built when WB_TIMEOUT_EN is defined.
module axi4l_wb_bridge #(
  parameter int ADDR_SHIFT     = 2,
  parameter int WB_DW          = 8,
  parameter int LANE           = 2,
  parameter int WB_AW          = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // AXI4-Lite: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits for ready, ready may depend on valid.
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [31:0]          aw_addr,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [31:0]          w_data,
  input  logic [3:0]           w_strb,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [1:0]           b_resp,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [31:0]          ar_addr,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [31:0]          r_data,
  output logic [1:0]           r_resp,
  output logic [WB_AW-1:0]     wb_adr_o,
  output logic [WB_DW-1:0]     wb_dat_o,
  output logic [WB_DW/8-1:0]   wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  input  logic [WB_DW-1:0]     wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB_WR  = 3'd1,
    WB_RD  = 3'd2,
    B_RESP = 3'd3,
    R_RESP = 3'd4
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  state_t state, state_n;
  logic   prio_rd;
  logic   wr_elig, rd_pick;
  logic   in_wb, wb_term, tmo_hit, wb_done, wb_fail;
  logic [WB_DW-1:0]   wr_lane;
  logic [WB_DW/8-1:0] sel_lane;

  assign wr_lane  = w_data[LANE*WB_DW +: WB_DW];
  assign sel_lane = w_strb[LANE*(WB_DW/8) +: WB_DW/8];
  assign wr_elig  = aw_valid & w_valid;
  // Read wins a collision unless it was the type served most recently.
  assign rd_pick  = ar_valid & (~wr_elig | prio_rd);

  assign in_wb    = (state == WB_WR) | (state == WB_RD);
  assign wb_term  = wb_ack_i | wb_err_i;
  assign wb_done  = in_wb & (wb_term | tmo_hit);
  assign wb_fail  = wb_err_i | tmo_hit;

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (aw_ready | ar_ready) begin
      tmo_cnt <= '0;
    end else if (in_wb & ~wb_term) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = in_wb & ~wb_term & (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    ar_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst_i) begin
          if (rd_pick) begin
            ar_ready = 1'b1;
            state_n  = WB_RD;
          end else if (wr_elig) begin
            aw_ready = 1'b1;
            w_ready  = 1'b1;
            // A write with no strobes in our lane has nothing to do on the bus.
            state_n  = (|sel_lane) ? WB_WR : B_RESP;
          end
        end
      end
      WB_WR:   if (wb_done) state_n = B_RESP;
      WB_RD:   if (wb_done) state_n = R_RESP;
      B_RESP:  if (b_ready) state_n = IDLE;
      R_RESP:  if (r_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_rd  <= 1'b1;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      b_resp   <= OKAY;
      r_resp   <= OKAY;
      r_data   <= '0;
    end else begin
      if (ar_ready) begin
        wb_adr_o <= ar_addr[ADDR_SHIFT +: WB_AW];
        wb_sel_o <= '1;
        prio_rd  <= 1'b0;
      end else if (aw_ready) begin
        wb_adr_o <= aw_addr[ADDR_SHIFT +: WB_AW];
        wb_dat_o <= wr_lane;
        wb_sel_o <= sel_lane;
        prio_rd  <= 1'b1;
        if (~|sel_lane) b_resp <= OKAY;
      end
      if (wb_done && state == WB_WR) begin
        b_resp <= wb_fail ? SLVERR : OKAY;
      end
      if (wb_done && state == WB_RD) begin
        r_resp <= wb_fail ? SLVERR : OKAY;
        r_data <= wb_fail ? 32'd0 : (32'(wb_dat_i) << (LANE * WB_DW));
      end
    end
  end

  assign wb_cyc_o  = in_wb;
  assign wb_stb_o  = in_wb;
  assign wb_we_o   = (state == WB_WR);
  assign b_valid   = (state == B_RESP);
  assign r_valid   = (state == R_RESP);
  assign fsm_state = state;

  // Address bits above/below the Wishbone window and other data lanes are dropped.
  logic unused_bits;
  assign unused_bits = ^{aw_addr, ar_addr, w_data, w_strb, 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_axi4l_wb_bridge.sv
// Directed self-checking bench for axi4l_wb_bridge with a scripted Wishbone slave.
// Timeout behaviour is exercised when WB_TIMEOUT_EN is defined.
module tb_axi4l_wb_bridge;

`ifdef WB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
  logic        b_ready = 1'b0, r_ready = 1'b0;
  logic [31:0] aw_addr = '0, ar_addr = '0, w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [0:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [7:0]  wb_dat_i = 8'h00;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [2:0]  fsm_state;

  axi4l_wb_bridge #(.ADDR_SHIFT(2), .WB_DW(8), .LANE(2), .WB_AW(3),
                    .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scripted Wishbone slave ----------------
  // wb_mode: 0 ack, 1 err, 2 ack+err, 3 never terminate
  int   wb_mode = 0, wb_wait = 0;
  int   stb_rises = 0, cur_len = 0, last_len = 0, unstable = 0;
  bit   prev_stb = 1'b0, stray_ack = 1'b0, term;
  logic [7:0] wb_rd_val = 8'h00;
  logic [2:0] snap_adr = '0;
  logic [7:0] snap_dat = '0;
  logic       snap_sel = 1'b0, snap_we = 1'b0;

  always @(negedge clk) begin
    term = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      if (!prev_stb) begin
        stb_rises++;
        snap_adr = wb_adr_o; snap_dat = wb_dat_o; snap_sel = wb_sel_o[0]; snap_we = wb_we_o;
        cur_len = 0;
      end else if (wb_adr_o != snap_adr || wb_dat_o != snap_dat ||
                   wb_sel_o[0] != snap_sel || wb_we_o != snap_we) begin
        unstable++;
      end
      cur_len++;
      term = (cur_len > wb_wait) && (wb_mode != 3);
    end else if (prev_stb) begin
      last_len = cur_len;
    end
    prev_stb = wb_cyc_o && wb_stb_o;
    wb_ack_i = (term && (wb_mode == 0 || wb_mode == 2)) || stray_ack;
    wb_err_i = term && (wb_mode == 1 || wb_mode == 2);
    wb_dat_i = term ? wb_rd_val : 8'hEE;
  end

  // ---------------- driver tasks ----------------
  // who: 1 read accepted, 2 write accepted, 0 none within budget
  task automatic wait_accept(output int who, output int at);
    who = 0; at = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (ar_ready) begin who = 1; at = cycle; break; end
      if (aw_ready && w_ready) begin who = 2; at = cycle; break; end
      @(negedge clk);
    end
    check("accept_seen", 32'(who != 0), 1);
  endtask

  task automatic wait_resp(input bit rd, output logic [1:0] resp, output int at);
    bit seen = 1'b0;
    resp = 2'b11; at = 0;
    if (rd) r_ready = 1'b1; else b_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (rd ? r_valid : b_valid) begin
        seen = 1'b1; at = cycle;
        resp = rd ? r_resp : b_resp;
        if (rd) begin
          check("sb_nonempty", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("r_data", r_data, exp_q.pop_front());
        end
        break;
      end
      @(negedge clk);
    end
    check("resp_seen", 32'(seen), 1);
    @(negedge clk);
    r_ready = 1'b0; b_ready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int who, c0, c1;
    @(negedge clk);
    aw_addr = a; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1;
    wait_accept(who, c0);
    check("wr_winner", who, 2);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    wait_resp(1'b0, resp, c1);
    lat = c1 - c0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [1:0] resp, output int lat);
    int who, c0, c1;
    @(negedge clk);
    ar_addr = a; ar_valid = 1'b1;
    wait_accept(who, c0);
    check("rd_winner", who, 1);
    @(negedge clk);
    ar_valid = 1'b0;
    wait_resp(1'b1, resp, c1);
    lat = c1 - c0;
  endtask

  // n back-to-back collisions, then the leftover channel drains; winners alternate.
  task automatic collide(input int n, input int first);
    int who, c0, c1, expw;
    logic [1:0] rs;
    @(negedge clk);
    wb_mode = 0; wb_wait = 0; wb_rd_val = 8'h42;
    ar_addr = 32'h10; aw_addr = 32'h18; w_data = 32'h0077_0000; w_strb = 4'h4;
    ar_valid = 1'b1; aw_valid = 1'b1; w_valid = 1'b1;
    for (int k = 0; k <= n; k++) begin
      expw = (k % 2 == 0) ? first : 3 - first;
      if (expw == 1) exp_q.push_back(32'h0042_0000);
      wait_accept(who, c0);
      check("collide_winner", who, expw);
      @(negedge clk);
      if (who == 0) begin
        ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        if (expw == 1) exp_q.delete();
        break;
      end
      if (k >= n - 1) begin
        if (who == 1) ar_valid = 1'b0;
        else begin aw_valid = 1'b0; w_valid = 1'b0; end
      end
      wait_resp(who == 1, rs, c1);
      check("collide_resp", rs, 2'b00);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [1:0] resp;
  int lat, rises0, who, c0;

  initial begin
    repeat (2) @(negedge clk);
    ar_valid = 1'b1;
    #1;
    check("rst_ar_ready", ar_ready, 0);
    check("rst_aw_ready", aw_ready, 0);
    check("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("rst_wb_regs", {wb_adr_o, wb_dat_o, wb_sel_o}, 12'h000);
    check("rst_valids", {b_valid, r_valid}, 2'b00);
    check("rst_resp_data", {b_resp, r_resp, r_data}, 36'h0);
    check("rst_state", fsm_state, 3'd0);
    @(negedge clk);
    ar_valid = 1'b0; rst_i = 1'b0;

    // write with one wait state
    wb_mode = 0; wb_wait = 1; rises0 = stb_rises;
    axi_write(32'h0C, 32'h00AB_0000, 4'h4, resp, lat);
    check("w1_adr", snap_adr, 3);
    check("w1_dat", snap_dat, 8'hAB);
    check("w1_sel", snap_sel, 1);
    check("w1_we", snap_we, 1);
    check("w1_stb_pulses", stb_rises - rises0, 1);
    check("w1_stb_len", last_len, 2);
    check("w1_stable", unstable, 0);
    check("w1_bresp", resp, 2'b00);
    check("w1_latency", lat, 3);

    // zero-wait write: minimum latency
    wb_wait = 0;
    axi_write(32'h04, 32'h0011_0000, 4'h4, resp, lat);
    check("w2_adr", snap_adr, 1);
    check("w2_dat", snap_dat, 8'h11);
    check("w2_latency", lat, 2);

    // read with r_ready held low for three cycles
    exp_q.push_back(32'h005A_0000);
    @(negedge clk);
    ar_addr = 32'h14; ar_valid = 1'b1; wb_rd_val = 8'h5A;
    wait_accept(who, c0);
    check("r1_winner", who, 1);
    @(negedge clk);
    ar_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (r_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("r1_hold_valid", r_valid, 1);
      check("r1_hold_data", r_data, 32'h005A_0000);
    end
    wait_resp(1'b1, resp, lat);
    check("r1_rresp", resp, 2'b00);
    check("r1_adr", snap_adr, 5);
    check("r1_sel", snap_sel, 1);
    check("r1_we", snap_we, 0);

    // zero strobe in lane 2: no bus cycle
    rises0 = stb_rises;
    axi_write(32'h08, 32'h0099_0000, 4'hB, resp, lat);
    check("w0_no_cyc", stb_rises - rises0, 0);
    check("w0_bresp", resp, 2'b00);
    check("w0_latency", lat, 1);

    // collisions after a write: read, write, read, then leftover write
    collide(3, 1);

    // error terminations
    wb_mode = 1; wb_rd_val = 8'h77;
    exp_q.push_back(32'h0);
    axi_read(32'h18, resp, lat);
    check("rerr_rresp", resp, 2'b10);
    wb_mode = 2;
    exp_q.push_back(32'h0);
    axi_read(32'h1C, resp, lat);
    check("rackerr_rresp", resp, 2'b10);
    axi_write(32'h00, 32'h0033_0000, 4'h4, resp, lat);
    check("wackerr_bresp", resp, 2'b10);

    // no termination from the slave
    wb_mode = 3;
`ifdef WB_TIMEOUT_EN
    exp_q.push_back(32'h0);
    axi_read(32'h04, resp, lat);
    check("tmo_rresp", resp, 2'b10);
    check("tmo_cyc_len", last_len, 4);
`else
    exp_q.push_back(32'h0066_0000);
    @(negedge clk);
    ar_addr = 32'h04; ar_valid = 1'b1; wb_rd_val = 8'h66;
    wait_accept(who, c0);
    @(negedge clk);
    ar_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("nohang_cyc", wb_cyc_o, 1);
    check("nohang_rvalid", r_valid, 0);
    wb_mode = 0;
    wait_resp(1'b1, resp, lat);
    check("nohang_rresp", resp, 2'b00);
`endif

    // termination strobes while idle are ignored
    wb_mode = 0;
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    #1;
    check("stray_idle", {fsm_state, b_valid, r_valid, wb_cyc_o}, 6'b000000);
    @(negedge clk);

    // reset in the middle of a Wishbone read
    wb_mode = 3;
    ar_addr = 32'h0C; ar_valid = 1'b1;
    wait_accept(who, c0);
    @(negedge clk);
    ar_valid = 1'b0;
    @(negedge clk); #1;
    check("mid_cyc", wb_cyc_o, 1);
    check("mid_state", fsm_state, 3'd2);
    rst_i = 1'b1;
    @(negedge clk); #1;
    check("abort_cyc", wb_cyc_o, 0);
    check("abort_rvalid", r_valid, 0);
    check("abort_state", fsm_state, 3'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_resp", {r_valid, b_valid}, 2'b00);

    // priority is back to read after reset; read then write complete normally
    collide(1, 1);
    check("post_rst_adr", snap_adr, 3'd6);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
